// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: one radix-2 shift-add or restoring-divide
// step per cycle on operand magnitudes, followed by a one-cycle sign fix-up.
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            flush,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] op1,
  input  logic [XLEN-1:0] op2,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_DIV    = 3'd4;
  localparam logic [2:0] OP_REM    = 3'd6;

  logic [1:0]        state;
  logic [CW-1:0]     count;
  logic [2:0]        op_q;
  logic              neg_a;
  logic              neg_b;
  logic [XLEN-1:0]   mag_b;
  // Multiply: {high, low} product with the multiplier shifting out of low.
  // Divide: high holds the partial remainder, low the dividend/quotient.
  logic [2*XLEN-1:0] acc;

  logic              op1_signed;
  logic              op2_signed;
  logic              sign_a;
  logic              sign_b;
  logic [XLEN:0]     abs1;
  logic [XLEN:0]     abs2;
  logic              div_zero;
  logic              div_ovf;
  logic [XLEN-1:0]   special_res;

  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     div_shift;
  logic [XLEN:0]     div_diff;
  logic [2*XLEN-1:0] acc_next;
  logic [2*XLEN-1:0] mul_fix;
  logic [XLEN-1:0]   quo;
  logic [XLEN-1:0]   rem;
  logic [XLEN-1:0]   fix_res;

  // Operand decode for an incoming start.
  always_comb begin
    op1_signed = (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
    op2_signed = (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    sign_a     = op1_signed & op1[XLEN-1];
    sign_b     = op2_signed & op2[XLEN-1];
    // Sign-extended one bit so that |-2^(XLEN-1)| is representable.
    abs1       = sign_a ? (~{op1[XLEN-1], op1} + 1'b1) : {1'b0, op1};
    abs2       = sign_b ? (~{op2[XLEN-1], op2} + 1'b1) : {1'b0, op2};
    div_zero   = op[2] && (op2 == '0);
    div_ovf    = ((op == OP_DIV) || (op == OP_REM)) &&
                 (op1 == {1'b1, {(XLEN-1){1'b0}}}) && (&op2);
    if (div_zero) special_res = op[1] ? op1 : '1;
    else          special_res = op[1] ? '0 : op1;
  end

  // One iteration step and the final sign correction.
  // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
  always_comb begin
    mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, mag_b} : '0);
    div_shift = acc[2*XLEN-1:XLEN-1];
    div_diff  = div_shift - {1'b0, mag_b};
    if (!op_q[2])        acc_next = {mul_sum, acc[XLEN-1:1]};
    else if (div_diff[XLEN]) acc_next = {div_shift[XLEN-1:0], acc[XLEN-2:0], 1'b0};
    else                 acc_next = {div_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};

    mul_fix = (neg_a ^ neg_b) ? (~acc + 1'b1) : acc;
    quo     = acc[XLEN-1:0];
    rem     = acc[2*XLEN-1:XLEN];
    if (!op_q[2])     fix_res = (op_q == OP_MUL) ? mul_fix[XLEN-1:0] : mul_fix[2*XLEN-1:XLEN];
    else if (op_q[1]) fix_res = neg_a ? (~rem + 1'b1) : rem;
    else              fix_res = (neg_a ^ neg_b) ? (~quo + 1'b1) : quo;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      count  <= '0;
      op_q   <= '0;
      neg_a  <= 1'b0;
      neg_b  <= 1'b0;
      mag_b  <= '0;
      acc    <= '0;
      result <= '0;
    end else if (flush) begin
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            op_q  <= op;
            neg_a <= sign_a;
            neg_b <= sign_b;
            mag_b <= abs2[XLEN-1:0];
            acc   <= {{XLEN{1'b0}}, abs1[XLEN-1:0]};
            count <= '0;
            if (div_zero || div_ovf) begin
              result <= special_res;
              state  <= S_DONE;
            end else begin
              state <= S_CALC;
            end
          end
        end
        S_CALC: begin
          acc   <= acc_next;
          count <= count + 1'b1;
          if (count == CW'(XLEN-1)) state <= S_FIX;
        end
        S_FIX: begin
          result <= fix_res;
          state  <= S_DONE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy = (state == S_CALC) || (state == S_FIX);
  assign done = (state == S_DONE) && !flush;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: stimulus pushes expected result and latency,
// a done-triggered monitor pops and compares.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic [2:0]  op = '0;
  logic [31:0] op1 = '0;
  logic [31:0] op2 = '0;
  logic        busy;
  logic        done;
  logic [31:0] result;

  muldiv_unit #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .start(start), .flush(flush), .op(op),
    .op1(op1), .op2(op2), .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    int          start_cyc;
    int          lat;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cycle = 0;
  int   done_count = 0;
  int   ops_expected = 0;

  always @(posedge clk) cycle++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && done === 1'b1) begin
      exp_t e;
      done_count++;
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: done=1 with no operation outstanding (cycle %0d)", cycle);
      end else begin
        e = sb_q.pop_front();
        check("result", result, e.res);
        check("latency", 32'(cycle - e.start_cyc), 32'(e.lat));
      end
    end
  end

  // Issue one operation, check busy each cycle, wait (bounded) for done.
  // With poke set, a conflicting start is driven mid-operation and must be ignored.
  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input int lat, input bit poke);
    int  n0;
    bit  got;
    @(negedge clk);
    op = o; op1 = a; op2 = b; start = 1'b1;
    sb_q.push_back('{exp, cycle, lat});
    ops_expected++;
    n0  = done_count;
    got = 1'b0;
    for (int k = 1; k <= lat + 20 && !got; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (poke && k == 5) begin
        start = 1'b1; op = 3'd0; op1 = 32'd3; op2 = 32'd3;
      end
      #1;
      if (k <= lat) check("busy", {31'b0, busy}, {31'b0, (k < lat)});
      if (done_count != n0) got = 1'b1;
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL timeout: no done for op %0d got none expected done", o);
      if (sb_q.size() > 0) void'(sb_q.pop_front());
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("reset_busy", {31'b0, busy}, 32'd0);
    check("reset_done", {31'b0, done}, 32'd0);
    check("reset_result", result, 32'd0);
    rst = 1'b0;

    run_op(3'd4, 32'd7,        32'hFFFF_FFFE, 32'hFFFF_FFFD, 34, 1'b1); // DIV 7/-2, mid-op start ignored
    run_op(3'd6, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 34, 1'b0); // REM -7%2
    run_op(3'd7, 32'hFFFF_FFF9, 32'd2,        32'd1,         34, 1'b0); // REMU
    run_op(3'd5, 32'h1234,     32'd0,         32'hFFFF_FFFF, 1,  1'b0); // DIVU by zero
    run_op(3'd6, 32'h1234,     32'd0,         32'h1234,      1,  1'b0); // REM by zero
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 1'b0); // DIV overflow
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1, 1'b0); // REM overflow
    run_op(3'd5, 32'd100,      32'd7,         32'd14,        34, 1'b0); // DIVU
    run_op(3'd7, 32'd100,      32'd7,         32'd2,         34, 1'b0); // REMU
    run_op(3'd4, 32'hFFFF_FF9C, 32'd7,        32'hFFFF_FFF2, 34, 1'b0); // DIV -100/7 = -14
    run_op(3'd6, 32'hFFFF_FF9C, 32'd7,        32'hFFFF_FFFE, 34, 1'b0); // REM -100%7 = -2
    run_op(3'd4, 32'h8000_0000, 32'd1,        32'h8000_0000, 34, 1'b0); // DIV min/1
    run_op(3'd0, 32'h1234_5678, 32'h10,       32'h2345_6780, 34, 1'b0); // MUL
    run_op(3'd1, 32'hFFFF_FFFF, 32'd3,        32'hFFFF_FFFF, 34, 1'b0); // MULH -1*3
    run_op(3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1,        34, 1'b0); // MUL
    run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34, 1'b0); // MULHU
    run_op(3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34, 1'b0); // MULH
    run_op(3'd2, 32'hFFFF_FFFF, 32'd2,        32'hFFFF_FFFF, 34, 1'b0); // MULHSU

    // Flush a DIV at cycle 10: no done, result keeps the MULHSU value.
    @(negedge clk);
    op = 3'd4; op1 = 32'd100; op2 = 32'd7; start = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (k == 10) flush = 1'b1;
    end
    @(negedge clk);
    flush = 1'b0;
    #1;
    check("flush_busy", {31'b0, busy}, 32'd0);
    check("flush_done", {31'b0, done}, 32'd0);
    check("flush_result", result, 32'hFFFF_FFFF);
    run_op(3'd0, 32'd3, 32'd5, 32'd15, 34, 1'b0);

    // Flush and start together: nothing launches.
    @(negedge clk);
    op = 3'd0; op1 = 32'd3; op2 = 32'd5; start = 1'b1; flush = 1'b1;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    #1;
    check("flush_start_busy", {31'b0, busy}, 32'd0);

    // Reset mid-operation: abandoned silently, result cleared.
    @(negedge clk);
    op = 3'd5; op1 = 32'd100; op2 = 32'd7; start = 1'b1;
    repeat (5) begin
      @(negedge clk);
      start = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_mid_busy", {31'b0, busy}, 32'd0);
    check("rst_mid_result", result, 32'd0);

    repeat (40) @(negedge clk);
    check("done_count", 32'(done_count), 32'(ops_expected));
    check("sb_empty", 32'(sb_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
